sonic_sensor_array: RTL

SONIC_SENSOR_ARRAY -- requirements
Module: sonic_sensor_array

---
 rtl/sonic_sensor_array.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sonic_sensor_array.sv
// Multi-channel ultrasonic ranger: triggers each masked channel in turn, times its echo and queues results.
// Continuous round-robin scanning is built only when SONIC_SCAN_EN is defined.
module sonic_sensor_array #(
  parameter int NUM_CH         = 4,
  parameter int TRIG_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 3000000,
  parameter int HOLDOFF_CYCLES = 6000000,
  parameter int RES_DEPTH      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [31:0]       res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [NUM_CH-1:0] trig_out,
  input  logic [NUM_CH-1:0] echo_in,
  output logic              busy,
  output logic [2:0]        led_out
);

  localparam int          AW        = $clog2(RES_DEPTH);
  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);
  localparam logic [23:0] TMO_LAST  = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, PUSH, HOLDOFF
  } state_t;

  state_t            r_state, w_next;
  logic [NUM_CH-1:0] r_mask;
  logic [NUM_CH-1:0] r_echo_m, r_echo_s;
  logic [NUM_CH-1:0] w_sel_src, w_pick_onehot, w_sel_onehot;
  logic [3:0]        r_sel, w_pick_idx;
  logic [31:0]       r_cnt;
  logic [23:0]       r_tmo, r_width;
  logic              r_flag, r_last_tmo;
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic [31:0]       r_mem [RES_DEPTH];
  logic              w_empty, w_full, w_push, w_pop, w_cmd_acc;
  logic              w_echo, w_tmo_hit;
  logic              w_unused;

  assign w_unused = ^cmd_data;

`ifdef SONIC_SCAN_EN
  logic              r_scan;
  logic [NUM_CH-1:0] r_orig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan <= 1'b0;
      r_orig <= '0;
    end else if (w_cmd_acc) begin
      r_scan <= cmd_data[16];
      r_orig <= cmd_data[NUM_CH-1:0];
    end
  end

  // An exhausted mask reloads from the original command while scanning.
  assign w_sel_src = (r_mask == '0 && r_scan) ? r_orig : r_mask;
  assign cmd_ready = (r_state == IDLE) || (r_scan && r_state == HOLDOFF);
`else
  assign w_sel_src = r_mask;
  assign cmd_ready = (r_state == IDLE);
`endif

  assign w_cmd_acc     = cmd_valid && cmd_ready;
  assign w_pick_onehot = w_sel_src & (~w_sel_src + NUM_CH'(1));
  assign w_sel_onehot  = NUM_CH'(1) << r_sel;
  assign w_echo        = |(r_echo_s & w_sel_onehot);
  assign w_tmo_hit     = (r_tmo == TMO_LAST);

  always_comb begin
    w_pick_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_sel_src[i]) w_pick_idx = 4'(i);
    end
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign res_valid = !w_empty;
  assign w_pop     = res_valid && res_ready;
  // A simultaneous pop frees the slot, so a full buffer still accepts the push.
  assign w_push    = (r_state == PUSH) && (!w_full || w_pop);
  assign res_data  = w_empty ? 32'd0 : r_mem[r_rd_ptr[AW-1:0]];

  assign trig_out = (r_state == TRIG) ? w_sel_onehot : '0;
  assign busy     = (r_state != IDLE);
  assign led_out  = {r_last_tmo, busy, res_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_cmd_acc) w_next = SELECT;
      SELECT:    w_next = (w_sel_src == '0) ? IDLE : TRIG;
      TRIG:      if (r_cnt == TRIG_LAST) w_next = WAIT_RISE;
      WAIT_RISE: begin
        if (w_tmo_hit)   w_next = PUSH;
        else if (w_echo) w_next = MEASURE;
      end
      MEASURE:   if (w_tmo_hit || !w_echo) w_next = PUSH;
      PUSH:      if (w_push) w_next = HOLDOFF;
      HOLDOFF:   if (r_cnt == HOLD_LAST) w_next = SELECT;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask     <= '0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_width    <= '0;
      r_flag     <= 1'b0;
      r_last_tmo <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_echo_m   <= '0;
      r_echo_s   <= '0;
    end else begin
      r_echo_m <= echo_in;
      r_echo_s <= r_echo_m;
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      case (r_state)
        SELECT: begin
          r_sel  <= w_pick_idx;
          r_mask <= w_sel_src & ~w_pick_onehot;
          r_cnt  <= '0;
        end
        TRIG: begin
          r_cnt   <= r_cnt + 32'd1;
          r_tmo   <= '0;
          r_width <= '0;
          r_flag  <= 1'b0;
        end
        // The first high sample is counted here so the width covers the whole pulse.
        WAIT_RISE: begin
          r_tmo <= r_tmo + 24'd1;
          if (w_tmo_hit)   r_flag  <= 1'b1;
          else if (w_echo) r_width <= 24'd1;
        end
        MEASURE: begin
          r_tmo <= r_tmo + 24'd1;
          if (w_tmo_hit)   r_flag  <= 1'b1;
          else if (w_echo) r_width <= r_width + 24'd1;
        end
        PUSH: begin
          if (w_push) begin
            r_last_tmo <= r_flag;
            r_cnt      <= '0;
          end
        end
        HOLDOFF: r_cnt <= r_cnt + 32'd1;
        default: ;
      endcase
      if (w_cmd_acc) r_mask <= cmd_data[NUM_CH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {r_flag, 3'b000, r_sel, r_width};
  end

endmodule
